// File: rtl/wam_pkg.sv
// ============================================================================
//  Module      : wam_pkg
//  Description : Shared types and constants for the whack-a-mole score keeper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wam_pkg;

   // Game state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } wam_state_t;

   // Number of holes on the board
   localparam int WAM_HOLES = 8;

   // Width of one BCD digit
   localparam int BCD_W = 4;

endpackage : wam_pkg

`default_nettype wire

// File: rtl/wam_bcd_add.sv
// ============================================================================
//  Module      : wam_bcd_add
//  Description : Combinational 3-digit BCD adder. Adds a 0-8 operand with an
//                optional -1, floors at 0, saturates at SCORE_MAX and flags
//                when the hundreds digit of the result grows.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wam_bcd_add
   import wam_pkg::*;
#(
   parameter logic [11:0] SCORE_MAX = 12'h999
) (
   input  logic [11:0] score_i,
   input  logic [3:0]  add_i,
   input  logic        dec_i,
   output logic [11:0] sum_o,
   output logic        hcarry_o
);

   logic [BCD_W-1:0] w_add;
   logic             w_do_dec;
   logic [4:0]       w_ones;
   logic [4:0]       w_tens;
   logic [4:0]       w_hund;
   logic             w_c1;
   logic             w_c2;
   logic             w_ovf;
   logic [11:0]      w_inc;
   logic [11:0]      w_decr;
   logic [11:0]      w_res;

   // Fold the -1 into the addend when possible; otherwise a pure decrement
   always_comb begin
      w_add    = add_i;
      w_do_dec = 1'b0;
      if (dec_i) begin
         if (add_i != 4'd0) begin
            w_add = add_i - 4'd1;
         end else begin
            w_add    = 4'd0;
            w_do_dec = 1'b1;
         end
      end
   end

   // Ripple BCD addition of the small addend, digit by digit
   always_comb begin
      w_c1   = 1'b0;
      w_c2   = 1'b0;
      w_ovf  = 1'b0;
      w_ones = {1'b0, score_i[3:0]} + {1'b0, w_add};
      if (w_ones > 5'd9) begin
         w_ones = w_ones - 5'd10;
         w_c1   = 1'b1;
      end
      w_tens = {1'b0, score_i[7:4]} + {4'd0, w_c1};
      if (w_tens > 5'd9) begin
         w_tens = 5'd0;
         w_c2   = 1'b1;
      end
      w_hund = {1'b0, score_i[11:8]} + {4'd0, w_c2};
      if (w_hund > 5'd9) begin
         w_hund = 5'd9;
         w_ovf  = 1'b1;
      end
      w_inc = {w_hund[3:0], w_tens[3:0], w_ones[3:0]};
   end

   // BCD decrement with borrow; zero stays at zero (floor)
   always_comb begin
      w_decr = score_i;
      if (score_i != 12'h000) begin
         if (score_i[3:0] != 4'd0) begin
            w_decr[3:0] = score_i[3:0] - 4'd1;
         end else begin
            w_decr[3:0] = 4'd9;
            if (score_i[7:4] != 4'd0) begin
               w_decr[7:4] = score_i[7:4] - 4'd1;
            end else begin
               w_decr[7:4]  = 4'd9;
               w_decr[11:8] = score_i[11:8] - 4'd1;
            end
         end
      end
   end

   // Select result and apply the ceiling; valid BCD compares like binary
   always_comb begin
      w_res = w_do_dec ? w_decr : w_inc;
      if ((!w_do_dec && w_ovf) || (w_res > SCORE_MAX)) begin
         w_res = SCORE_MAX;
      end
      sum_o    = w_res;
      hcarry_o = (w_res[11:8] > score_i[11:8]);
   end

endmodule : wam_bcd_add

`default_nettype wire

// File: rtl/wam_scr.sv
// ============================================================================
//  Module      : wam_scr
//  Description : Whack-a-mole score and hardness keeper. Scores tap pulses
//                against raised moles in BCD, tracks the hardness level and
//                runs the IDLE/PLAY/DONE game state.
//                Build option: define WAM_PENALTY_EN to make a wrong tap
//                subtract one point.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wam_scr
   import wam_pkg::*;
#(
   parameter logic [3:0]  HRDN_MIN  = 4'd1,
   parameter logic [3:0]  HRDN_MAX  = 4'd9,
   parameter logic [11:0] SCORE_MAX = 12'h999
) (
   input  logic        clk_19,
   input  logic        rst_n,
   input  logic [7:0]  holes,
   input  logic [7:0]  tap,
   input  logic        lft,
   input  logic        rgt,
   input  logic        start,
   input  logic        stop,
   output logic [11:0] score,
   output logic [3:0]  hrdn,
   output logic        cout0,
   output logic        playing
);

   wam_state_t  state_q, state_d;
   logic [11:0] score_q, score_d;
   logic [3:0]  hrdn_q, hrdn_d;
   logic        cout0_q, cout0_d;
   logic        playing_q, playing_d;

   logic [7:0]  w_hit_vec;
   logic [3:0]  w_hits;
   logic        w_miss;
   logic [11:0] w_sum;
   logic        w_hcarry;
   logic        w_scoring;
   logic        w_auto;
   logic [4:0]  w_hsum;

   assign w_hit_vec = tap & holes;

   // Count correct taps this cycle
   always_comb begin
      w_hits = 4'd0;
      for (int i = 0; i < WAM_HOLES; i++) begin
         w_hits = w_hits + {3'd0, w_hit_vec[i]};
      end
   end

`ifdef WAM_PENALTY_EN
   assign w_miss = |(tap & ~holes);
`else
   assign w_miss = 1'b0;
`endif

   wam_bcd_add #(
      .SCORE_MAX (SCORE_MAX)
   ) u_bcd_add (
      .score_i  (score_q),
      .add_i    (w_hits),
      .dec_i    (w_miss),
      .sum_o    (w_sum),
      .hcarry_o (w_hcarry)
   );

   // Taps only count in PLAY, and never in the cycle that accepts start
   assign w_scoring = (state_q == ST_PLAY) && !start;
   assign w_auto    = w_scoring && w_hcarry;

   // Next game state and score; start always wins over stop
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      if (start) begin
         state_d = ST_PLAY;
         score_d = 12'h000;
      end else if (state_q == ST_PLAY) begin
         score_d = w_sum;
         if (stop || (w_sum == SCORE_MAX)) begin
            state_d = ST_DONE;
         end
      end
   end

   // Next hardness: manual step plus automatic level-up, clamped to range
   always_comb begin
      w_hsum = {1'b0, hrdn_q} + {4'd0, rgt} + {4'd0, w_auto};
      if (lft) begin
         w_hsum = w_hsum - 5'd1;
      end
      if (w_hsum < {1'b0, HRDN_MIN}) begin
         hrdn_d = HRDN_MIN;
      end else if (w_hsum > {1'b0, HRDN_MAX}) begin
         hrdn_d = HRDN_MAX;
      end else begin
         hrdn_d = w_hsum[3:0];
      end
      cout0_d   = w_auto;
      playing_d = (state_d == ST_PLAY);
   end

   // Game state register
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output registers
   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         score_q   <= 12'h000;
         hrdn_q    <= HRDN_MIN;
         cout0_q   <= 1'b0;
         playing_q <= 1'b0;
      end else begin
         score_q   <= score_d;
         hrdn_q    <= hrdn_d;
         cout0_q   <= cout0_d;
         playing_q <= playing_d;
      end
   end

   assign score   = score_q;
   assign hrdn    = hrdn_q;
   assign cout0   = cout0_q;
   assign playing = playing_q;

endmodule : wam_scr

`default_nettype wire

// File: tb/tb_wam_scr.sv
// ============================================================================
//  Module      : tb_wam_scr
//  Description : Self-checking bench for wam_scr with a behavioural model
//                working in plain integers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wam_scr;

   logic        clk_19;
   logic        rst_n;
   logic [7:0]  holes;
   logic [7:0]  tap;
   logic        lft;
   logic        rgt;
   logic        start;
   logic        stop;
   logic [11:0] score;
   logic [3:0]  hrdn;
   logic        cout0;
   logic        playing;

   int n_tests;
   int n_fail;

   // behavioural model: integer score 0..999, hardness 1..9, state 0/1/2
   int m_score;
   int m_hrdn;
   int m_state;
   bit m_cout;
   bit m_play;

   wam_scr dut (
      .clk_19  (clk_19),
      .rst_n   (rst_n),
      .holes   (holes),
      .tap     (tap),
      .lft     (lft),
      .rgt     (rgt),
      .start   (start),
      .stop    (stop),
      .score   (score),
      .hrdn    (hrdn),
      .cout0   (cout0),
      .playing (playing)
   );

   initial clk_19 = 1'b0;
   always #5 clk_19 = ~clk_19;

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   function automatic void model_reset();
      m_score = 0;
      m_hrdn  = 1;
      m_state = 0;
      m_cout  = 1'b0;
      m_play  = 1'b0;
   endfunction

   function automatic void model_step(input logic [7:0] h, input logic [7:0] t,
                                      input logic l, input logic r,
                                      input logic s, input logic p);
      int hits, miss, ns, nh;
      bit au;
      au = 1'b0;
      if (s) begin
         m_score = 0;
         m_state = 1;
      end else if (m_state == 1) begin
         hits = $countones(t & h);
`ifdef WAM_PENALTY_EN
         miss = ((t & ~h) != 8'h00) ? 1 : 0;
`else
         miss = 0;
`endif
         ns = m_score + hits - miss;
         if (ns < 0) ns = 0;
         if (ns > 999) ns = 999;
         au = (ns / 100) > (m_score / 100);
         if (p || ns == 999) m_state = 2;
         m_score = ns;
      end
      nh = m_hrdn + int'(r) - int'(l) + int'(au);
      if (nh < 1) nh = 1;
      if (nh > 9) nh = 9;
      m_hrdn = nh;
      m_cout = au;
      m_play = (m_state == 1);
   endfunction

   // Drive one cycle of inputs, advance the model, land 1 unit after the edge
   task automatic cycle(input logic [7:0] h, input logic [7:0] t,
                        input logic l, input logic r,
                        input logic s, input logic p);
      holes = h; tap = t; lft = l; rgt = r; start = s; stop = p;
      @(posedge clk_19);
      model_step(h, t, l, r, s, p);
      #1;
      holes = 8'h00; tap = 8'h00; lft = 1'b0; rgt = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   // Raise the score in PLAY with hits only, up to target
   task automatic climb(input int target);
      logic [7:0] mk;
      int n;
      while (m_score < target) begin
         n  = target - m_score;
         if (n > 8) n = 8;
         mk = 8'hFF >> (8 - n);
         cycle(mk, mk, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      holes = 8'h00; tap = 8'h00; lft = 1'b0; rgt = 1'b0; start = 1'b0; stop = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_19);
      #1;
      rst_n = 1'b1;
      n_tests++; if (score !== 12'h000) begin n_fail++; $display("FAIL reset_score got %h want 000", score); end
      n_tests++; if (hrdn !== 4'd1) begin n_fail++; $display("FAIL reset_hrdn got %0d want 1", hrdn); end
      n_tests++; if (cout0 !== 1'b0) begin n_fail++; $display("FAIL reset_cout0 got %b want 0", cout0); end
      n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got %b want 0", playing); end
   endtask

   task automatic test_basic_hit();
      // taps in IDLE must be ignored
      cycle(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== 12'h000) begin n_fail++; $display("FAIL idle_tap got %h want 000", score); end
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++; if (playing !== 1'b1) begin n_fail++; $display("FAIL start_playing got %b want 1", playing); end
      cycle(8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== 12'h002) begin n_fail++; $display("FAIL basic_score got %h want 002", score); end
      n_tests++; if (hrdn !== 4'd1) begin n_fail++; $display("FAIL basic_hrdn got %0d want 1", hrdn); end
      n_tests++; if (cout0 !== 1'b0) begin n_fail++; $display("FAIL basic_cout0 got %b want 0", cout0); end
   endtask

   task automatic test_carry_levelup();
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      climb(98);
      n_tests++; if (score !== 12'h098) begin n_fail++; $display("FAIL preload_98 got %h want 098", score); end
      cycle(8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== 12'h101) begin n_fail++; $display("FAIL carry_score got %h want 101", score); end
      n_tests++; if (hrdn !== 4'd2) begin n_fail++; $display("FAIL carry_hrdn got %0d want 2", hrdn); end
      n_tests++; if (cout0 !== 1'b1) begin n_fail++; $display("FAIL carry_cout0 got %b want 1", cout0); end
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (cout0 !== 1'b0) begin n_fail++; $display("FAIL cout0_once got %b want 0", cout0); end
   endtask

   task automatic test_penalty();
      logic [11:0] exp10;
`ifdef WAM_PENALTY_EN
      exp10 = 12'h009;
`else
      exp10 = 12'h010;
`endif
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== 12'h000) begin n_fail++; $display("FAIL penalty_floor got %h want 000", score); end
      climb(10);
      cycle(8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== exp10) begin n_fail++; $display("FAIL penalty_10 got %h want %h", score, exp10); end
      n_tests++; if (score !== to_bcd(m_score)) begin n_fail++; $display("FAIL penalty_model got %h want %h", score, to_bcd(m_score)); end
   endtask

   task automatic test_hardness();
      repeat (10) cycle(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++; if (hrdn !== 4'd9) begin n_fail++; $display("FAIL hrdn_max got %0d want 9", hrdn); end
      cycle(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++; if (hrdn !== 4'd9) begin n_fail++; $display("FAIL hrdn_cancel got %0d want 9", hrdn); end
      cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++; if (hrdn !== 4'd8) begin n_fail++; $display("FAIL hrdn_down got %0d want 8", hrdn); end
      repeat (11) cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++; if (hrdn !== 4'd1) begin n_fail++; $display("FAIL hrdn_min got %0d want 1", hrdn); end
   endtask

   task automatic test_saturation();
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      climb(997);
      n_tests++; if (hrdn !== 4'(m_hrdn)) begin n_fail++; $display("FAIL climb_hrdn got %0d want %0d", hrdn, m_hrdn); end
      cycle(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== 12'h999) begin n_fail++; $display("FAIL sat_score got %h want 999", score); end
      n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL sat_playing got %b want 0", playing); end
      cycle(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (score !== 12'h999) begin n_fail++; $display("FAIL done_frozen got %h want 999", score); end
      cycle(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      n_tests++; if (score !== 12'h000) begin n_fail++; $display("FAIL restart_score got %h want 000", score); end
      n_tests++; if (playing !== 1'b1) begin n_fail++; $display("FAIL restart_playing got %b want 1", playing); end
      cycle(8'h0F, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL stop_playing got %b want 0", playing); end
      n_tests++; if (score !== 12'h002) begin n_fail++; $display("FAIL stop_cycle_score got %h want 002", score); end
   endtask

   task automatic test_async_reset();
      repeat (12) cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      climb(345);
      n_tests++; if (score !== 12'h345 || hrdn !== 4'd4) begin n_fail++; $display("FAIL pre_reset got %h/%0d want 345/4", score, hrdn); end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++; if (score !== 12'h000) begin n_fail++; $display("FAIL async_score got %h want 000", score); end
      n_tests++; if (hrdn !== 4'd1) begin n_fail++; $display("FAIL async_hrdn got %0d want 1", hrdn); end
      n_tests++; if (playing !== 1'b0 || cout0 !== 1'b0) begin n_fail++; $display("FAIL async_flags got %b%b want 00", playing, cout0); end
      @(posedge clk_19);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] h, t;
      logic l, r, s, p;
      for (int k = 0; k < 600; k++) begin
         h = 8'($urandom);
         t = 8'($urandom) & 8'($urandom);
         l = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 3) == 0);
         s = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
         p = ($urandom_range(0, 47) == 0);
         cycle(h, t, l, r, s, p);
         n_tests++;
         if (score !== to_bcd(m_score) || hrdn !== 4'(m_hrdn) || cout0 !== m_cout || playing !== m_play) begin
            n_fail++;
            $display("FAIL rand_%0d got s=%h h=%0d c=%b p=%b want s=%h h=%0d c=%b p=%b",
                     k, score, hrdn, cout0, playing, to_bcd(m_score), m_hrdn, m_cout, m_play);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_basic_hit();
      test_carry_levelup();
      test_penalty();
      test_hardness();
      test_saturation();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_wam_scr

`default_nettype wire
